// File: rtl/datamem_pkg.sv
// Shared definitions for the multi-read-port data memory: clear FSM state
// encodings and default geometry.
package datamem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_RD_DEF = 2;

endpackage

// File: rtl/datamem_clr_fsm.sv
// Clear sequencer for datamem_mp: sweeps every word to zero after reset or on
// clr_req, and tracks writes that arrive while the sweep is running.
module datamem_clr_fsm
  import datamem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr_req,
  input  logic              wr_en,
  output logic              busy,
  output logic              wr_drop,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  clr_state_e        state_r;
  clr_state_e        state_nxt_s;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic              busy_r;
  logic              wr_drop_r;
  logic              clr_we_s;

  // State register; reset always lands in CLEAR so the array starts zeroed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a request seen during CLEAR does not restart the sweep.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) state_nxt_s = ST_CLEAR;
        else         state_nxt_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (clr_ptr_r == PTR_LAST) state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_CLEAR;
      end
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // Sweep pointer, busy flag and sticky dropped-write flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_ptr_r <= {ADDR_W{1'b0}};
      busy_r    <= 1'b1;
      wr_drop_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_CLEAR);
      case (state_r)
        ST_IDLE: begin
          if (clr_req) begin
            clr_ptr_r <= {ADDR_W{1'b0}};
            wr_drop_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_ptr_r <= clr_ptr_r + PTR_ONE;
          if (wr_en) wr_drop_r <= 1'b1;
        end
        default: clr_ptr_r <= {ADDR_W{1'b0}};
      endcase
    end
  end

  // Clear-write strobe onto the array write port.
  always_comb begin
    clr_we_s = 1'b0;
    if (state_r == ST_CLEAR) clr_we_s = 1'b1;
    else                     clr_we_s = 1'b0;
  end

  assign busy     = busy_r;
  assign wr_drop  = wr_drop_r;
  assign clr_we   = clr_we_s;
  assign clr_addr = clr_ptr_r;

endmodule

// File: rtl/datamem_mp.sv
// Multi-read-port data memory: one write port, NUM_RD registered read ports
// and a hardware clear sequencer. Define DATAMEM_FWD_EN for write-first
// read-during-write behaviour; otherwise reads return the old word.
module datamem_mp
  import datamem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              user_we_s;

  datamem_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .wr_en    (wr_en),
    .busy     (busy_s),
    .wr_drop  (wr_drop),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  assign busy      = busy_s;
  assign user_we_s = wr_en & ~busy_s;

  // Array write port: the clear sweep owns it while busy, user writes otherwise.
  always_ff @(posedge clock) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s] <= {DATA_W{1'b0}};
    end else if (user_we_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] word_s;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;

    assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];

`ifdef DATAMEM_FWD_EN
    // Per-port forward of same-cycle write data (write-first).
    always_comb begin
      word_s = mem_r[addr_s];
      if (user_we_s && (wr_addr == addr_s)) word_s = wr_data;
      else                                  word_s = mem_r[addr_s];
    end
`else
    assign word_s = mem_r[addr_s];
`endif

    // Read register; data holds its last value when the port is not serviced.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_r  <= {DATA_W{1'b0}};
        valid_r <= 1'b0;
      end else if (rd_en[k] && !busy_s) begin
        data_r  <= word_s;
        valid_r <= 1'b1;
      end else begin
        valid_r <= 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_r;
    assign rd_valid[k]                 = valid_r;
  end

endmodule

// File: tb/tb_datamem_mp.sv
// Scoreboard bench for datamem_mp (default geometry, two read ports).
module tb_datamem_mp;

  logic        clock;
  logic        reset_n;
  logic        clr_req;
  logic        busy;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic        wr_drop;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

`ifdef DATAMEM_FWD_EN
  localparam logic [7:0] EXP_T3 = 8'h3C;
`else
  localparam logic [7:0] EXP_T3 = 8'h11;
`endif

  datamem_mp #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_drop  (wr_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever a port presents valid data.
  always @(negedge clock) begin
    if (rd_valid[0] === 1'b1) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd0_unexpected: got valid data %0h expected no read at %0t", rd_data[7:0], $time);
      end else begin
        chk("rd0_data", {24'h0, rd_data[7:0]}, {24'h0, exp_q0.pop_front()});
      end
    end
    if (rd_valid[1] === 1'b1) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd1_unexpected: got valid data %0h expected no read at %0t", rd_data[15:8], $time);
      end else begin
        chk("rd1_data", {24'h0, rd_data[15:8]}, {24'h0, exp_q1.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd2(input logic [3:0] a0, input logic [3:0] a1,
                     input logic [7:0] e0, input logic [7:0] e1);
    rd_en = 2'b11; rd_addr = {a1, a0};
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
    tick();
    rd_en = 2'b00;
  endtask

  // Counts busy cycles (bounded) and checks no read is reported meanwhile.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      chk("valid_while_busy", {30'h0, rd_valid}, 32'h0);
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [3:0] a4;
    reset_n = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = 4'h0;
    wr_data = 8'h00; rd_en = 2'b00; rd_addr = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_valid", {30'h0, rd_valid}, 32'h0);
    chk("rst_data", {16'h0, rd_data}, 32'h0);
    chk("rst_drop", {31'h0, wr_drop}, 32'h0);

    // T1: reset clear length, then every word reads zero
    reset_n = 1'b1;
    wait_idle(n);
    chk("t1_busy_len", n, 32'd16);
    for (int a = 0; a < 16; a++) begin
      a4 = a[3:0];
      rd2(a4, 4'd15 - a4, 8'h00, 8'h00);
    end
    tick();

    // T2: write then read on both ports
    wr(4'd3, 8'hA5);
    rd2(4'd3, 4'd3, 8'hA5, 8'hA5);
    tick();

    // T3: read-during-write on the same address
    wr(4'd7, 8'h11);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
    rd_en = 2'b11; rd_addr = {4'd7, 4'd7};
    exp_q0.push_back(EXP_T3);
    exp_q1.push_back(EXP_T3);
    tick();
    wr_en = 1'b0; rd_en = 2'b00;
    rd2(4'd7, 4'd3, 8'h3C, 8'hA5);
    tick();

    // T4: write during clear is dropped and flagged
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    chk("t4_busy", {31'h0, busy}, 32'h1);
    repeat (4) tick();
    wr(4'd5, 8'h77);
    chk("t4_drop_set", {31'h0, wr_drop}, 32'h1);
    rd_en = 2'b11; rd_addr = {4'd5, 4'd5};
    tick();
    rd_en = 2'b00;
    wait_idle(n);
    chk("t4_drop_hold", {31'h0, wr_drop}, 32'h1);
    rd2(4'd5, 4'd3, 8'h00, 8'h00);
    tick();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    chk("t4_drop_clr", {31'h0, wr_drop}, 32'h0);
    wait_idle(n);
    chk("t4_busy_len", n, 32'd16);

    // T5: fill with 0xFF, clear mid-operation with reads requested
    for (int a = 0; a < 16; a++) begin
      a4 = a[3:0];
      wr(a4, 8'hFF);
    end
    rd2(4'd0, 4'd15, 8'hFF, 8'hFF);
    rd2(4'd9, 4'd6, 8'hFF, 8'hFF);
    tick();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    rd_en = 2'b11; rd_addr = {4'd15, 4'd0};
    wait_idle(n);
    rd_en = 2'b00;
    chk("t5_busy_len", n, 32'd16);
    for (int a = 0; a < 16; a++) begin
      a4 = a[3:0];
      rd2(a4, a4, 8'h00, 8'h00);
    end
    tick();

    // T6: reset mid-clear at clr_ptr=9
    wr(4'd2, 8'h5A);
    rd2(4'd2, 4'd2, 8'h5A, 8'h5A);
    tick();
    chk("t6_rd_hold", {16'h0, rd_data}, 32'h5A5A);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (8) tick();
    wr(4'd1, 8'h01);
    chk("t6_drop_set", {31'h0, wr_drop}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_data", {16'h0, rd_data}, 32'h0);
    chk("t6_rst_valid", {30'h0, rd_valid}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy}, 32'h1);
    chk("t6_rst_drop", {31'h0, wr_drop}, 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    wait_idle(n);
    chk("t6_busy_len", n, 32'd16);
    rd2(4'd2, 4'd9, 8'h00, 8'h00);
    tick();
    tick();

    chk("q0_drained", exp_q0.size(), 32'd0);
    chk("q1_drained", exp_q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
